// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/data arbiter in front of a single-port variable-latency memory
//
// Ports:
//   clk, reset                  clock and synchronous active-low reset
//   if_req, if_addr             fetch request, held until if_valid
//   if_rdata, if_valid          fetched instruction and its one-cycle completion pulse
//   dm_req, dm_we, dm_addr,     data request (load/store), held until dm_valid
//   dm_wdata
//   dm_rdata, dm_valid          load data and its one-cycle completion pulse
//   stall_if, stall_mem         combinational stall requests to the hazard logic
//   mem_req, mem_we, mem_addr,  registered request toward memory, held until ack or abort
//   mem_wdata
//   mem_rdata, mem_ack          memory response, single-cycle ack
//   err                         one-cycle pulse when an access is aborted on timeout
module mem_port_arbiter #(
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int MAX_DSTREAK = 4,
    parameter int TIMEOUT     = 64
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_valid,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic [DW-1:0] dm_rdata,
    output logic          dm_valid,
    output logic          stall_if,
    output logic          stall_mem,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack,
    output logic          err
);

    localparam int SW = (MAX_DSTREAK < 1) ? 1 : $clog2(MAX_DSTREAK + 1);
    localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DSTREAK);
    localparam logic [TW-1:0] TO_LAST    = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    state_t        state;
    logic [SW-1:0] streak;
    logic [TW-1:0] tcnt;
    logic          if_want;
    logic          dm_want;

    // A requester whose valid is high is still holding the tail of the
    // access that just completed; it must not win a second grant.
    always_comb begin
        if_want = if_req & ~if_valid;
        dm_want = dm_req & ~dm_valid;
    end

    assign stall_if  = if_req & ~if_valid;
    assign stall_mem = dm_req & ~dm_valid;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            streak    <= '0;
            tcnt      <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_rdata  <= '0;
            dm_rdata  <= '0;
            if_valid  <= 1'b0;
            dm_valid  <= 1'b0;
            err       <= 1'b0;
        end else begin
            if_valid <= 1'b0;
            dm_valid <= 1'b0;
            err      <= 1'b0;
            case (state)
                IDLE: begin
                    // Data wins unless a fetch is waiting and data has
                    // already taken MAX_DSTREAK grants in a row.
                    if (dm_want && (!if_want || streak != STREAK_MAX)) begin
                        state     <= BUSY_D;
                        mem_req   <= 1'b1;
                        mem_we    <= dm_we;
                        mem_addr  <= dm_addr;
                        mem_wdata <= dm_wdata;
                        tcnt      <= '0;
                        streak    <= if_want ? streak + SW'(1) : '0;
                    end else if (if_want) begin
                        state     <= BUSY_I;
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_addr  <= if_addr;
                        mem_wdata <= '0;
                        tcnt      <= '0;
                        streak    <= '0;
                    end
                end
                BUSY_I, BUSY_D: begin
                    if (mem_ack) begin
                        state   <= IDLE;
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        if (state == BUSY_I) begin
                            if_rdata <= mem_rdata;
                            if_valid <= 1'b1;
                        end else begin
                            if (!mem_we) begin
                                dm_rdata <= mem_rdata;
                            end
                            dm_valid <= 1'b1;
                        end
                    end else if (tcnt == TO_LAST) begin
                        // Dead memory: complete the access with zero data
                        // so the pipeline can proceed, and flag it.
                        state   <= IDLE;
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        err     <= 1'b1;
                        if (state == BUSY_I) begin
                            if_rdata <= '0;
                            if_valid <= 1'b1;
                        end else begin
                            dm_rdata <= '0;
                            dm_valid <= 1'b1;
                        end
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
